r5p_bus_arb: RTL and testbench

R5P_BUS_ARB -- requirements
Module: r5p_bus_arb

---
 rtl/r5p_pkg.sv | 35 +++
 rtl/r5p_bus_arb_sel.sv | 41 ++++
 rtl/r5p_bus_arb.sv | 153 +++++++++++++++
 tb/tb_r5p_bus_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_pkg.sv
// r5p_pkg -- shared types for the r5p bus arbiter.
//
// Contents:
//   gnt_e      : grant FSM states (who holds a stalled request on the memory port)
//   rsp_e      : owner of the read response arriving on the next cycle
//   sel_t      : one-hot requester select, bit SEL_IF = fetch, bit SEL_LS = load/store
//   sel_to_rsp : maps a one-hot select to the matching response owner
package r5p_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LS   = 2'd2
  } gnt_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_e;

  localparam int unsigned SEL_IF = 0;
  localparam int unsigned SEL_LS = 1;

  typedef logic [1:0] sel_t;

  function automatic rsp_e sel_to_rsp(input sel_t sel);
    rsp_e r;
    r = RSP_NONE;
    if (sel[SEL_LS])      r = RSP_LS;
    else if (sel[SEL_IF]) r = RSP_IF;
    return r;
  endfunction

endpackage

// File: rtl/r5p_bus_arb_sel.sv
// r5p_bus_arb_sel -- requester selection for the r5p bus arbiter.
//
// Purely combinational. A locked grant state always wins so a stalled
// request is never switched away from; otherwise a lone requester is taken,
// and contention is settled by the priority pointer.
//
// Ports:
//   if_vld_i  : fetch requester valid
//   ls_vld_i  : load/store requester valid
//   gnt_i     : current grant FSM state (GNT_IF/GNT_LS mean locked)
//   ptr_ls_i  : 1 = load/store wins contention, 0 = fetch wins
//   sel_o     : one-hot select (bit SEL_IF / bit SEL_LS), zero when nobody asks
module r5p_bus_arb_sel
  import r5p_pkg::*;
(
  input  logic if_vld_i,
  input  logic ls_vld_i,
  input  gnt_e gnt_i,
  input  logic ptr_ls_i,
  output sel_t sel_o
);

  always_comb begin
    sel_o = '0;
    case (gnt_i)
      GNT_IF: sel_o[SEL_IF] = 1'b1;
      GNT_LS: sel_o[SEL_LS] = 1'b1;
      default: begin
        if (if_vld_i && ls_vld_i) begin
          if (ptr_ls_i) sel_o[SEL_LS] = 1'b1;
          else          sel_o[SEL_IF] = 1'b1;
        end else if (ls_vld_i) begin
          sel_o[SEL_LS] = 1'b1;
        end else if (if_vld_i) begin
          sel_o[SEL_IF] = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/r5p_bus_arb.sv
// r5p_bus_arb -- two-requester arbiter in front of a single memory port.
//
// Handshake: every port uses valid/ready. A transfer happens on a cycle where
// valid and ready are both high; the requester holds valid and its fields
// stable until then. Read data comes back on m_rdt exactly one cycle after
// the accepting cycle and is steered to the requester that issued the read.
//
// Build option: define R5P_BUS_ARB_RR_EN for round-robin arbitration on
// contention (1-bit pointer, reset to load/store). Without it the load/store
// requester always wins contention and no pointer register exists.
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   if_vld/if_adr                 : fetch request (read-only)
//   if_rdy/if_rdt                 : fetch accept / read data
//   ls_vld/ls_wen/ls_adr/ls_ben/ls_wdt : load/store request
//   ls_rdy/ls_rdt                 : load/store accept / read data
//   m_vld/m_wen/m_adr/m_ben/m_wdt : shared memory request
//   m_rdy/m_rdt                   : memory accept / read data (one cycle later)
//   dbg_gnt_o                     : grant FSM state
//   dbg_rsp_o                     : response owner register
module r5p_bus_arb
  import r5p_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = DW/8
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch requester
  input  logic            if_vld,
  input  logic [AW-1:0]   if_adr,
  output logic            if_rdy,
  output logic [BW*8-1:0] if_rdt,
  // load/store requester
  input  logic            ls_vld,
  input  logic            ls_wen,
  input  logic [AW-1:0]   ls_adr,
  input  logic [BW-1:0]   ls_ben,
  input  logic [BW*8-1:0] ls_wdt,
  output logic            ls_rdy,
  output logic [BW*8-1:0] ls_rdt,
  // memory port
  output logic            m_vld,
  output logic            m_wen,
  output logic [AW-1:0]   m_adr,
  output logic [BW-1:0]   m_ben,
  output logic [BW*8-1:0] m_wdt,
  input  logic            m_rdy,
  input  logic [BW*8-1:0] m_rdt,
  // debug
  output gnt_e            dbg_gnt_o,
  output rsp_e            dbg_rsp_o
);

  gnt_e gnt_q, gnt_d;
  rsp_e rsp_q, rsp_d;
  logic ptr_ls;
  sel_t sel_raw, sel;
  logic sel_if, sel_ls, acc;

  r5p_bus_arb_sel u_sel (
    .if_vld_i (if_vld),
    .ls_vld_i (ls_vld),
    .gnt_i    (gnt_q),
    .ptr_ls_i (ptr_ls),
    .sel_o    (sel_raw)
  );

  // Reset masks the select combinationally so the memory port and both
  // ready outputs go quiet the moment rst_n falls, not at the next edge.
  assign sel    = rst_n ? sel_raw : '0;
  assign sel_if = sel[SEL_IF];
  assign sel_ls = sel[SEL_LS];

  always_comb begin
    m_vld = (sel_if & if_vld) | (sel_ls & ls_vld);
    m_wen = sel_ls & ls_wen;
    m_adr = '0;
    m_ben = '0;
    m_wdt = '0;
    if (sel_ls) begin
      m_adr = ls_adr;
      m_ben = ls_ben;
      m_wdt = ls_wdt;
    end else if (sel_if) begin
      m_adr = if_adr;
      m_ben = '1;          // fetch always reads the full word
    end
  end

  // The locked owner sees m_rdy even if it dropped valid; that cycle moves
  // no data because m_vld follows the owner's valid.
  assign if_rdy = sel_if & m_rdy;
  assign ls_rdy = sel_ls & m_rdy;
  assign acc    = m_vld & m_rdy;

  // Grant FSM: remembers who owns a stalled request. Leaving a locked state
  // on a dropped valid stops a vanished request from blocking the port.
  always_comb begin
    gnt_d = gnt_q;
    case (gnt_q)
      GNT_IDLE: if (m_vld && !m_rdy) gnt_d = sel_ls ? GNT_LS : GNT_IF;
      GNT_IF:   if (m_rdy || !if_vld) gnt_d = GNT_IDLE;
      GNT_LS:   if (m_rdy || !ls_vld) gnt_d = GNT_IDLE;
      default:  gnt_d = GNT_IDLE;
    endcase
  end

  // Writes produce no response, so only accepted reads load an owner.
  always_comb begin
    rsp_d = RSP_NONE;
    if (acc && !m_wen) rsp_d = sel_to_rsp(sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= GNT_IDLE;
      rsp_q <= RSP_NONE;
    end else begin
      gnt_q <= gnt_d;
      rsp_q <= rsp_d;
    end
  end

`ifdef R5P_BUS_ARB_RR_EN
  // After any accepted transfer the pointer moves to the requester that was
  // not served, so back-to-back contention alternates.
  logic ptr_ls_q, ptr_ls_d;

  always_comb begin
    ptr_ls_d = ptr_ls_q;
    if (acc) ptr_ls_d = ~sel_ls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_ls_q <= 1'b1;
    else        ptr_ls_q <= ptr_ls_d;
  end

  assign ptr_ls = ptr_ls_q;
`else
  assign ptr_ls = 1'b1;
`endif

  assign if_rdt = (rsp_q == RSP_IF) ? m_rdt : '0;
  assign ls_rdt = (rsp_q == RSP_LS) ? m_rdt : '0;

  assign dbg_gnt_o = gnt_q;
  assign dbg_rsp_o = rsp_q;

endmodule

// File: tb/tb_r5p_bus_arb.sv
// tb_r5p_bus_arb -- self-checking bench for r5p_bus_arb (AW=DW=32).
// Driver applies inputs on the falling edge and runs a reference model that
// predicts memory transfers and routed read data; the monitor samples two
// time units later and checks DUT outputs against the expected queues.
module tb_r5p_bus_arb;
  import r5p_pkg::*;

  localparam int RW = 2 + 1 + 32 + 4 + 32;  // {owner, wen, adr, ben, wdt}

  logic        clk, rst_n;
  logic        if_vld, if_rdy;
  logic [31:0] if_adr, if_rdt;
  logic        ls_vld, ls_wen, ls_rdy;
  logic [31:0] ls_adr, ls_wdt, ls_rdt;
  logic [3:0]  ls_ben;
  logic        m_vld, m_wen, m_rdy;
  logic [31:0] m_adr, m_wdt, m_rdt;
  logic [3:0]  m_ben;
  gnt_e        dbg_gnt;
  rsp_e        dbg_rsp;

  r5p_bus_arb #(.AW(32), .DW(32), .BW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_vld(if_vld), .if_adr(if_adr), .if_rdy(if_rdy), .if_rdt(if_rdt),
    .ls_vld(ls_vld), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben),
    .ls_wdt(ls_wdt), .ls_rdy(ls_rdy), .ls_rdt(ls_rdt),
    .m_vld(m_vld), .m_wen(m_wen), .m_adr(m_adr), .m_ben(m_ben), .m_wdt(m_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt),
    .dbg_gnt_o(dbg_gnt), .dbg_rsp_o(dbg_rsp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [33:0]   rsp_q[$];     // {owner, data}; owner 1 = IF, 2 = LS
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Owners as ints: 0 none, 1 fetch, 2 load/store.
  int mdl_lock;   // requester holding a stalled request
  int mdl_ptr;    // requester that wins contention
  int mdl_rsp;    // requester owed read data this cycle
  int mdl_acc;    // requester whose transfer completes this cycle

  function automatic void model_eval();
    int own;
    logic vld;
    if (mdl_rsp != 0) rsp_q.push_back({mdl_rsp[1:0], m_rdt});
    mdl_rsp = 0;
    mdl_acc = 0;
    if (mdl_lock != 0)          own = mdl_lock;
    else if (if_vld && ls_vld)  own = mdl_ptr;
    else if (ls_vld)            own = 2;
    else if (if_vld)            own = 1;
    else                        own = 0;
    vld = (own == 1) ? if_vld : (own == 2) ? ls_vld : 1'b0;
    if (vld && m_rdy) begin
      if (own == 1) exp_q.push_back({2'd1, 1'b0, if_adr, 4'hF, 32'h0});
      else          exp_q.push_back({2'd2, ls_wen, ls_adr, ls_ben, ls_wdt});
      if (own == 1 || !ls_wen) mdl_rsp = own;
`ifdef R5P_BUS_ARB_RR_EN
      mdl_ptr = (own == 1) ? 2 : 1;
`endif
      mdl_acc  = own;
      mdl_lock = 0;
    end else if (vld) begin
      mdl_lock = own;
    end else begin
      mdl_lock = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic ifv, input logic [31:0] ifa,
                       input logic lsv, input logic lsw, input logic [31:0] lsa,
                       input logic [3:0] lsb, input logic [31:0] lsd,
                       input logic mr, input logic [31:0] mrd);
    @(negedge clk);
    if_vld = ifv; if_adr = ifa;
    ls_vld = lsv; ls_wen = lsw; ls_adr = lsa; ls_ben = lsb; ls_wdt = lsd;
    m_rdy = mr;   m_rdt = mrd;
    model_eval();
  endtask

  task automatic idle(input logic mr, input logic [31:0] mrd);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, mr, mrd);
  endtask

  task automatic clear_inputs();
    if_vld = 0; if_adr = '0; ls_vld = 0; ls_wen = 0; ls_adr = '0;
    ls_ben = '0; ls_wdt = '0; m_rdy = 0; m_rdt = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    clear_inputs();
    mdl_lock = 0; mdl_ptr = 2; mdl_rsp = 0; mdl_acc = 0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    int prev_rd;
    logic [RW-1:0] act, e;
    logic [33:0] r;
    prev_rd = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_rd = 0;
        continue;
      end
      if (prev_rd != 0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 128'(prev_rd), 128'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_owner", 128'(prev_rd), 128'(r[33:32]));
          check("if_rdt", if_rdt, (r[33:32] == 2'd1) ? r[31:0] : 32'h0);
          check("ls_rdt", ls_rdt, (r[33:32] == 2'd2) ? r[31:0] : 32'h0);
        end
      end else begin
        check("rdt_quiet", {if_rdt, ls_rdt}, 64'h0);
      end
      check("rdy_exclusive", if_rdy & ls_rdy, 1'b0);
      check("rdy_vs_xfer", if_rdy | ls_rdy, m_vld & m_rdy);
      prev_rd = 0;
      if (m_vld && m_rdy) begin
        act = {(ls_rdy ? 2'd2 : 2'd1), m_wen, m_adr, m_ben, m_wdt};
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", act, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("xfer", act, e);
        end
        if (!m_wen) prev_rd = ls_rdy ? 2 : 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        if_p, ls_p, ls_w;
    logic [31:0] if_a, ls_a, ls_d;
    logic [3:0]  ls_b;

    rst_n = 1'b0;
    clear_inputs();
    mdl_lock = 0; mdl_ptr = 2; mdl_rsp = 0; mdl_acc = 0;
    #1;
    check("rst_m_vld", m_vld, 1'b0);
    check("rst_rdy", {if_rdy, ls_rdy}, 2'b00);
    check("rst_rdt", {if_rdt, ls_rdt}, 64'h0);
    check("rst_gnt", dbg_gnt, GNT_IDLE);
    check("rst_rsp", dbg_rsp, RSP_NONE);
    do_reset(2);

`ifdef R5P_BUS_ARB_RR_EN
    // Continuous contention alternates starting from load/store.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 4'hF, 32'h0, 1'b1, $urandom);
      #3;
      check("rr_grant", {ls_rdy, if_rdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle(1'b1, $urandom);
`else
    // Lone fetch read.
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
    #3;
    check("if_alone_adr", m_adr, 32'h100);
    check("if_alone_rdy", if_rdy, 1'b1);
    check("if_alone_ben", {m_wen, m_ben}, 5'b0_1111);
    idle(1'b0, 32'hDEADBEEF);
    #3;
    check("if_alone_rdt", if_rdt, 32'hDEADBEEF);
    check("if_alone_ls_rdt", ls_rdt, 32'h0);

    // Contention: load/store first, fetch next cycle.
    cycle(1'b1, 32'h300, 1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, 1'b1, $urandom);
    #3;
    check("prio_adr", m_adr, 32'h2000);
    check("prio_if_rdy", if_rdy, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, $urandom);
    #3;
    check("prio_if_next", {m_adr, if_rdy}, {32'h300, 1'b1});

    // Stalled fetch keeps the port while load/store waits.
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, $urandom);
    #3;
    check("lock_adr0", m_adr, 32'h400);
    for (int i = 1; i < 3; i++) begin
      cycle(1'b1, 32'h400, 1'b1, 1'b0, 32'h2004, 4'hF, 32'h0, 1'b0, $urandom);
      #3;
      check("lock_adr", m_adr, 32'h400);
      check("lock_gnt", dbg_gnt, GNT_IF);
    end
    cycle(1'b1, 32'h400, 1'b1, 1'b0, 32'h2004, 4'hF, 32'h0, 1'b1, $urandom);
    #3;
    check("lock_release", {m_adr, if_rdy, ls_rdy}, {32'h400, 2'b10});
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 4'hF, 32'h0, 1'b1, $urandom);
    #3;
    check("lock_ls_served", {m_adr, ls_rdy}, {32'h2004, 1'b1});

    // Write: no response routed afterwards.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 4'b0011, 32'h0000A5A5, 1'b1, $urandom);
    #3;
    check("wr_fields", {m_wen, m_ben, m_wdt}, {1'b1, 4'b0011, 32'h0000A5A5});
    idle(1'b0, 32'h12345678);
    #3;
    check("wr_rsp", dbg_rsp, RSP_NONE);
    check("wr_ls_rdt", ls_rdt, 32'h0);

    // Locked owner drops valid: nothing moves, no switch that cycle.
    cycle(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, $urandom);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h2008, 4'hF, 32'h0, 1'b0, $urandom);
    #3;
    check("drop_m_vld", {m_vld, ls_rdy}, 2'b00);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h2008, 4'hF, 32'h0, 1'b1, $urandom);
    #3;
    check("drop_ls_served", {m_adr, ls_rdy}, {32'h2008, 1'b1});
    idle(1'b1, $urandom);
`endif

    // Reset while load/store is stalled.
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 4'hF, 32'h0, 1'b0, $urandom);
    cycle(1'b1, 32'h800, 1'b1, 1'b0, 32'h4000, 4'hF, 32'h0, 1'b0, $urandom);
    #3;
    check("pre_rst_gnt", dbg_gnt, GNT_LS);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {m_vld, if_rdy, ls_rdy, m_adr}, 35'h0);
    check("mid_rst_rdt", {if_rdt, ls_rdt}, 64'h0);
    do_reset(2);
    idle(1'b0, $urandom);
    #3;
    check("post_rst_gnt", dbg_gnt, GNT_IDLE);

    // Randomized traffic; requesters hold their request until accepted.
    if_p = 0; ls_p = 0; if_a = '0; ls_a = '0; ls_d = '0; ls_w = 0; ls_b = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!if_p && $urandom_range(0, 2) != 0) begin
        if_p = 1'b1;
        if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_p && $urandom_range(0, 2) != 0) begin
        ls_p = 1'b1;
        ls_w = 1'($urandom_range(0, 1));
        ls_a = $urandom;
        ls_b = 4'($urandom_range(0, 15));
        ls_d = $urandom;
      end
      cycle(if_p, if_a, ls_p, ls_w, ls_a, ls_b, ls_d,
            1'($urandom_range(0, 3) != 0), $urandom);
      if (mdl_acc == 1) if_p = 1'b0;
      if (mdl_acc == 2) ls_p = 1'b0;
    end
    // Finish outstanding requests, then let the last response drain.
    for (int i = 0; i < 8; i++) begin
      cycle(if_p, if_a, ls_p, ls_w, ls_a, ls_b, ls_d, 1'b1, $urandom);
      if (mdl_acc == 1) if_p = 1'b0;
      if (mdl_acc == 2) ls_p = 1'b0;
    end
    idle(1'b0, $urandom);
    idle(1'b0, $urandom);
    #3;
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("rsp_q_empty", 128'(rsp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
